fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of decode: owns the program counter and issues word reads to instruction memory.
- Buffers returned instructions, tagged with their PC, in a small prefetch queue and presents them to decode over a valid/ready handshake.
- Handles taken-branch redirects by flushing the queue and discarding any in-flight memory response.

Parameters:
- INSTR_ADDRW, 16, instruction address width (word-addressed; matches the 16-bit branch address field).
- INSTR_SIZE, 32, instruction width.
- DEPTH, 4, prefetch queue entries (power of 2, ≥2).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- imem_req  output  1  read request; accepted by memory in the same cycle it is high.
- imem_addr  output  INSTR_ADDRW  read address; valid while imem_req is high.
- imem_rvalid  input  1  read data valid, ≥1 cycle after the request; at most one response per request.
- imem_rdata  input  INSTR_SIZE  read data.
- branch_taken  input  1  redirect pulse from execute.
- branch_target  input  INSTR_ADDRW  redirect address.
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  decode accepts the head.
- instr  output  INSTR_SIZE  head instruction.
- instr_pc  output  INSTR_ADDRW  PC of the head instruction.
- queue_count  output  $clog2(DEPTH)+1  occupancy (debug).

Behaviour:
- Reset (rst=0 at an edge):
  - fetch_pc=RESET_PC; queue empty; state RUN.
  - instr_valid=0, instr=0, instr_pc=0, queue_count=0.
  - imem_req=0 while rst=0.
  - Reset mid-request: the pending response is ignored; no discard is carried across reset.
- States:
  - RUN: no request outstanding.
  - WAIT: one request outstanding; its response will be kept.
  - DROP: one request outstanding; its response will be discarded.
- Request outstanding limit: at most one.
- Request issue (combinational): imem_req=1 iff all of the following hold:
  - rst=1 and branch_taken=0;
  - state is RUN, or state is WAIT with imem_rvalid=1;
  - queue_count + (state==WAIT ? 1 : 0) < DEPTH, using the registered count with no credit for a same-cycle pop.
- Request addressing: imem_addr=fetch_pc. On issue, req_pc<=fetch_pc and fetch_pc<=fetch_pc+1, wrapping modulo 2^INSTR_ADDRW (0xFFFF -> 0x0000).
- Transitions:
  - RUN + issue -> WAIT.
  - WAIT + rvalid: push {req_pc, rdata}; go to WAIT if a new request issues, else RUN.
  - DROP + rvalid: discard the data -> RUN; no issue that cycle.
  - imem_rvalid in RUN is ignored.
- Queue:
  - Synchronous FIFO with circular pointers.
  - Pop occurs when instr_valid && instr_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - instr/instr_pc are driven from the head entry and are 0 when empty.
  - Latency: a response accepted at edge N appears on instr_valid after edge N.
- Redirect (branch_taken=1), which takes priority over all else:
  - Queue cleared (count=0, pointers reset); a pop presented this cycle is not performed.
  - Any same-cycle imem_rvalid data is discarded.
  - fetch_pc<=branch_target.
  - State WAIT (no rvalid this cycle) -> DROP; DROP stays DROP; otherwise -> RUN.
  - No request is issued in the redirect cycle; the first target request issues the next cycle (or after the drop completes).
- Invariant: the queue never overflows. A push while full is an assertion failure in the bench.

Test Plan:
- Reset with RESET_PC=0x0010, 1-cycle memory, instr_ready=1 -> requests to 0x0010, 0x0011, 0x0012 on consecutive cycles; decode sees instr_pc 0x0010, 0x0011, 0x0012 back-to-back, each with matching data.
- instr_ready=0 with DEPTH=4 -> exactly 4 entries fill, imem_req stays 0, queue_count=4; raising instr_ready drains 4 entries in order, then fetching resumes at the next PC.
- Memory latency 3 cycles, branch_taken with target 0x0100 asserted while a request to 0x0005 is outstanding -> queue empties the next cycle; the 0x0005 response is dropped; the next request is to 0x0100; the first instr_pc seen is 0x0100.
- branch_taken in the same cycle as imem_rvalid and instr_ready=1 with 2 entries queued -> no pop, no push, count=0, fetch_pc=target.
- fetch_pc=0xFFFF -> after the request, next imem_addr=0x0000; instr_pc sequence 0xFFFF, 0x0000.
- rst=0 asserted with a request outstanding and 3 entries queued -> next cycle instr_valid=0, queue_count=0; the stale rvalid arriving after reset is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Owns the program counter, issues one word read at a time to instruction
// memory, buffers returned words (tagged with their PC) in a small prefetch
// queue and hands them to decode over a valid/ready handshake. A taken branch
// flushes the queue and discards any in-flight memory response.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   imem_req/addr     read request (accepted in the cycle it is high) and address
//   imem_rvalid/rdata read response, at most one per request
//   branch_taken/target  redirect pulse and new fetch address
//   instr_valid/ready    handshake for the queue head towards decode
//   instr, instr_pc      head instruction and its PC (0 when empty)
//   queue_count          queue occupancy (debug)
module fetch_unit #(
    parameter int unsigned INSTR_ADDRW = 16,
    parameter int unsigned INSTR_SIZE  = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [INSTR_ADDRW-1:0] imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INSTR_SIZE-1:0]  imem_rdata,
    input  logic                   branch_taken,
    input  logic [INSTR_ADDRW-1:0] branch_target,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_SIZE-1:0]  instr,
    output logic [INSTR_ADDRW-1:0] instr_pc,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam int unsigned SUMW = CNTW + 1;

    // RUN: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [INSTR_ADDRW-1:0] fetch_pc;
    logic [INSTR_ADDRW-1:0] req_pc;
    logic [INSTR_SIZE-1:0]  q_data [DEPTH];
    logic [INSTR_ADDRW-1:0] q_pc   [DEPTH];
    logic [PTRW-1:0]        wr_ptr;
    logic [PTRW-1:0]        rd_ptr;
    logic [CNTW-1:0]        count;
    logic                   room;
    logic                   issue;
    logic                   push;
    logic                   pop;

    // An outstanding kept request reserves a slot; no credit for a same-cycle pop.
    assign room = (SUMW'(count) + SUMW'(state == WAIT)) < SUMW'(DEPTH);

    // Next state, request issue, queue push/pop.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        if (!rst) begin
            state_nxt = RUN;
        end else if (branch_taken) begin
            // A request still in flight must be drained before fetching the target.
            state_nxt = ((state != RUN) && !imem_rvalid) ? DROP : RUN;
        end else begin
            pop = instr_valid && instr_ready;
            case (state)
                RUN: begin
                    issue = room;
                    if (room) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push      = 1'b1;
                        issue     = room;
                        state_nxt = room ? WAIT : RUN;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Control state, PC and queue bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            fetch_pc <= INSTR_ADDRW'(RESET_PC);
            req_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (branch_taken) begin
                fetch_pc <= branch_target;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + INSTR_ADDRW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTRW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTRW'(1);
                end
                if (push && !pop) begin
                    count <= count + CNTW'(1);
                end else if (pop && !push) begin
                    count <= count - CNTW'(1);
                end
            end
        end
    end

    // Queue storage; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? q_pc[rd_ptr] : '0;
    assign queue_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table after reset, directed
// redirect/wrap/reset sequences, then randomized traffic checked against a
// stream-level model (fetch and delivery are consecutive PCs restarting at
// each redirect/reset).
module tb_fetch_unit;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] RST_PC = 16'h0010;

    logic          clk;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [CW-1:0] queue_count;

    int tests = 0;
    int fails = 0;

    fetch_unit #(
        .INSTR_ADDRW(AW),
        .INSTR_SIZE (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0000_0010)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .queue_count  (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {~a, a ^ 16'h5A3C};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- instruction memory model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rsp_t;

    rsp_t mq[$];
    int   cyc = 0;
    int   lat_fix = 1;
    bit   lat_rand = 1'b0;

    always @(posedge clk) begin
        rsp_t r;
        cyc++;
        if (mq.size() > 0 && mq[0].due == cyc) void'(mq.pop_front());
        if (imem_req === 1'b1) begin
            r.addr = imem_addr;
            r.due  = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_fix);
            mq.push_back(r);
        end
    end

    always @(negedge clk) begin
        if (mq.size() > 0 && mq[0].due == cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data_of(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    end

    // ---------------- stream-level reference monitor ----------------
    logic [AW-1:0] exp_req_pc = RST_PC;
    logic [AW-1:0] exp_pop_pc = RST_PC;
    bit            kept = 1'b0;     // a request whose data must be delivered is in flight
    bit            flushed = 1'b0;
    int            pops = 0;

    always @(posedge clk) begin
        if (flushed) begin
            check("flush_count", 32'(queue_count), 32'd0);
        end
        flushed = 1'b0;
        if (!rst) begin
            check("req_in_reset", 32'(imem_req), 32'd0);
            exp_req_pc = RST_PC;
            exp_pop_pc = RST_PC;
            kept       = 1'b0;
            flushed    = 1'b1;
        end else if (branch_taken) begin
            check("req_in_redirect", 32'(imem_req), 32'd0);
            exp_req_pc = branch_target;
            exp_pop_pc = branch_target;
            kept       = 1'b0;
            flushed    = 1'b1;
        end else begin
            check("count_bound", 32'(int'(queue_count) <= int'(DEPTH)), 32'd1);
            if (!instr_valid) begin
                check("empty_head", {instr_pc, instr[15:0]}, 32'd0);
            end
            if (kept && imem_rvalid && !(instr_valid && instr_ready)) begin
                check("no_overflow", 32'(int'(queue_count) < int'(DEPTH)), 32'd1);
            end
            if (imem_req) begin
                check("req_addr", 32'(imem_addr), 32'(exp_req_pc));
                check("req_limit",
                      32'((kept && !imem_rvalid) || (int'(queue_count) + int'(kept) >= int'(DEPTH))),
                      32'd0);
                exp_req_pc = exp_req_pc + AW'(1);
            end
            if (instr_valid && instr_ready) begin
                check("pop_pc", 32'(instr_pc), 32'(exp_pop_pc));
                check("pop_data", instr, data_of(exp_pop_pc));
                exp_pop_pc = exp_pop_pc + AW'(1);
                pops++;
            end
            if (imem_req) kept = 1'b1;
            else if (imem_rvalid) kept = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic          ready;
        logic          req;
        logic [AW-1:0] addr;
        logic          valid;
        logic [AW-1:0] pc;
        logic [CW-1:0] count;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bit found;
        int p0;

        // 1-cycle memory from reset at 0x0010, decode stalls from row 5, resumes at row 10.
        vecs[0]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 16'h0011, 1'b0, 16'h0000, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 16'h0012, 1'b1, 16'h0010, 3'd1};
        vecs[3]  = '{1'b1, 1'b1, 16'h0013, 1'b1, 16'h0011, 3'd1};
        vecs[4]  = '{1'b1, 1'b1, 16'h0014, 1'b1, 16'h0012, 3'd1};
        vecs[5]  = '{1'b0, 1'b1, 16'h0015, 1'b1, 16'h0013, 3'd1};
        vecs[6]  = '{1'b0, 1'b1, 16'h0016, 1'b1, 16'h0013, 3'd2};
        vecs[7]  = '{1'b0, 1'b0, 16'h0017, 1'b1, 16'h0013, 3'd3};
        vecs[8]  = '{1'b0, 1'b0, 16'h0017, 1'b1, 16'h0013, 3'd4};
        vecs[9]  = '{1'b0, 1'b0, 16'h0017, 1'b1, 16'h0013, 3'd4};
        vecs[10] = '{1'b1, 1'b0, 16'h0017, 1'b1, 16'h0013, 3'd4};
        vecs[11] = '{1'b1, 1'b1, 16'h0017, 1'b1, 16'h0014, 3'd3};
        vecs[12] = '{1'b1, 1'b1, 16'h0018, 1'b1, 16'h0015, 3'd2};
        vecs[13] = '{1'b1, 1'b1, 16'h0019, 1'b1, 16'h0016, 3'd2};
        vecs[14] = '{1'b1, 1'b1, 16'h001A, 1'b1, 16'h0017, 3'd2};

        rst           = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        lat_fix       = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_count", 32'(queue_count), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            instr_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
            check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(vecs[i].pc));
            check($sformatf("vec%0d_instr", i), instr,
                  vecs[i].valid ? data_of(vecs[i].pc) : 32'd0);
            check($sformatf("vec%0d_count", i), 32'(queue_count), 32'(vecs[i].count));
        end

        // Redirect to 0x0100 while the 3-cycle read of 0x0005 is in flight.
        lat_fix = 3;
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 16'h0005;
        @(negedge clk);
        branch_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (imem_req && imem_addr == 16'h0005) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_0005", 32'(found), 32'd1);
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 16'h0100;
        #1;
        check("br_inflight_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("br_inflight_count", 32'(queue_count), 32'd0);
        check("br_inflight_valid", 32'(instr_valid), 32'd0);
        check("drop_wait_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        check("drop_rsp_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        check("target_req", 32'(imem_req), 32'd1);
        check("target_addr", 32'(imem_addr), 32'h0100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("target_first_seen", 32'(found), 32'd1);
        check("target_first_pc", 32'(instr_pc), 32'h0100);

        // Redirect in the same cycle as a response, with two entries queued and decode ready.
        lat_fix     = 1;
        instr_ready = 1'b0;
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 16'h0300;
        @(negedge clk);
        branch_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (queue_count == 3'd2 && imem_rvalid) begin
                found = 1'b1;
                break;
            end
        end
        check("two_queued_seen", 32'(found), 32'd1);
        branch_taken  = 1'b1;
        branch_target = 16'h0200;
        instr_ready   = 1'b1;
        #1;
        check("br_rsp_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("br_rsp_count", 32'(queue_count), 32'd0);
        check("br_rsp_valid", 32'(instr_valid), 32'd0);
        check("br_rsp_req_next", 32'(imem_req), 32'd1);
        check("br_rsp_fetch_pc", 32'(imem_addr), 32'h0200);

        // PC wrap from 0xFFFF to 0x0000.
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        @(negedge clk);
        branch_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (imem_req && imem_addr == 16'hFFFF) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wrap_req_ffff", 32'(found), 32'd1);
        @(negedge clk);
        #1;
        check("wrap_req_next", 32'(imem_req), 32'd1);
        check("wrap_addr_next", 32'(imem_addr), 32'h0000);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("wrap_pop_seen", 32'(found), 32'd1);
        check("wrap_pop_ffff", 32'(instr_pc), 32'hFFFF);
        @(negedge clk);
        #1;
        check("wrap_pop_0000_valid", 32'(instr_valid), 32'd1);
        check("wrap_pop_0000", 32'(instr_pc), 32'h0000);

        // Reset with three entries queued and a 3-cycle read outstanding.
        lat_fix     = 3;
        instr_ready = 1'b0;
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        @(negedge clk);
        branch_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (queue_count == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        check("three_queued_seen", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_count", 32'(queue_count), 32'd0);
        check("mid_rst_instr", instr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", 32'(imem_addr), 32'(RST_PC));
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("post_rst_seen", 32'(found), 32'd1);
        check("post_rst_pc", 32'(instr_pc), 32'(RST_PC));
        check("post_rst_data", instr, data_of(RST_PC));

        // Randomized traffic against the stream model.
        lat_rand = 1'b1;
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            instr_ready  = ($urandom_range(0, 9) < 7);
            branch_taken = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0)
                branch_target = AW'(32'h0000_FFFC + $urandom_range(0, 3));
            else
                branch_target = AW'($urandom);
        end
        @(negedge clk);
        branch_taken = 1'b0;
        instr_ready  = 1'b1;
        repeat (30) @(negedge clk);
        check("random_progress", 32'((pops - p0) > 300), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
